// File: rtl/filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : filter_pkg
//  Description : Shared constants and types for the FIR filter datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package filter_pkg;

   localparam int FILTER_DATA_W  = 32;
   localparam int FILTER_SHIFT_W = 6;

   typedef logic [31:0] filter_word_t;

endpackage : filter_pkg
`default_nettype wire

// File: rtl/filter_shift_stage.sv
`default_nettype none
// ============================================================================
//  Module      : filter_shift_stage
//  Description : One stage of the barrel shifter. When enabled, shifts right
//                arithmetically by a fixed STAGE_AMT positions, filling the
//                vacated MSBs with the sign bit; otherwise passes through.
//                Amounts at or beyond the word width collapse to sign fill.
//  Revision    : 1.0 - initial release
// ============================================================================
module filter_shift_stage #(
   parameter int DATA_W    = 32,
   parameter int STAGE_AMT = 1
) (
   input  logic [DATA_W-1:0] din,
   input  logic              en,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] shifted_w;
   logic              sign_w;

   assign sign_w = din[DATA_W-1];

   // Pick the fixed shift shape at elaboration so no zero-width replication
   // or out-of-range part select is ever built.
   generate
      if (STAGE_AMT <= 0) begin : g_pass
         assign shifted_w = din;
      end else if (STAGE_AMT >= DATA_W) begin : g_sign_fill
         assign shifted_w = {DATA_W{sign_w}};
      end else begin : g_shift
         assign shifted_w = {{STAGE_AMT{sign_w}}, din[DATA_W-1:STAGE_AMT]};
      end
   endgenerate

   // Stage mux: shifted word when this bit of the shift amount is set.
   always_comb begin
      dout = din;
      if (en) begin
         dout = shifted_w;
      end
   end

endmodule : filter_shift_stage
`default_nettype wire

// File: rtl/filter_barrel_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : filter_barrel_shifter
//  Description : Registered arithmetic right barrel shifter. Scales the MAC
//                accumulator word by 0..2**SHIFT_W-1 positions with sign
//                extension; one clock of latency, one operand per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module filter_barrel_shifter
   import filter_pkg::*;
#(
   parameter int DATA_W  = FILTER_DATA_W,
   parameter int SHIFT_W = FILTER_SHIFT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DATA_W-1:0]  input_signal,
   input  logic [SHIFT_W-1:0] sel_shift,
   output logic [DATA_W-1:0]  output_signal
);

   // stage_w[0] is the raw operand; stage_w[k+1] has applied shift bit k.
   logic [DATA_W-1:0] stage_w [0:SHIFT_W];
   logic [DATA_W-1:0] output_signal_d;
   logic [DATA_W-1:0] output_signal_q;

   assign stage_w[0] = input_signal;

   // Log2 mux network: stage k shifts by 2**k. Stages whose weight reaches
   // the word width force full sign fill, so large amounts never alias.
   generate
      for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
         filter_shift_stage #(
            .DATA_W    (DATA_W),
            .STAGE_AMT (2 ** k)
         ) u_stage (
            .din  (stage_w[k]),
            .en   (sel_shift[k]),
            .dout (stage_w[k+1])
         );
      end
   endgenerate

   // Next output value is the fully shifted word.
   always_comb begin
      output_signal_d = stage_w[SHIFT_W];
   end

   // Output register; reset takes priority over any operand.
   always_ff @(posedge clk) begin
      if (reset) begin
         output_signal_q <= '0;
      end else begin
         output_signal_q <= output_signal_d;
      end
   end

   assign output_signal = output_signal_q;

endmodule : filter_barrel_shifter
`default_nettype wire

// File: tb/tb_filter_barrel_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_filter_barrel_shifter
//  Description : Directed and random self-checking bench for the registered
//                arithmetic right barrel shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_barrel_shifter;

   logic        clk;
   logic        reset;
   logic [31:0] input_signal;
   logic [5:0]  sel_shift;
   logic [31:0] output_signal;

   int n_cmp;
   int n_err;

   filter_barrel_shifter #(
      .DATA_W  (32),
      .SHIFT_W (6)
   ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .input_signal  (input_signal),
      .sel_shift     (sel_shift),
      .output_signal (output_signal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one operand, clock it in, then check the registered result.
   task automatic step(input string tag, input logic rst_i, input logic [31:0] din,
                       input logic [5:0] sh, input logic [31:0] exp);
      reset        = rst_i;
      input_signal = din;
      sel_shift    = sh;
      @(posedge clk);
      #1;
      check_eq(tag, output_signal, exp);
   endtask

   initial begin
      logic [31:0] rd;
      logic [5:0]  rs;
      logic [31:0] rexp;
      n_cmp = 0;
      n_err = 0;
      reset        = 1'b1;
      input_signal = 32'hABCD_1234;
      sel_shift    = 6'd0;

      // Reset holds the output at zero even with a live operand.
      step("reset_0", 1'b1, 32'hABCD_1234, 6'd0, 32'h0000_0000);
      step("reset_1", 1'b1, 32'hABCD_1234, 6'd0, 32'h0000_0000);
      step("pass_0",  1'b0, 32'hABCD_1234, 6'd0, 32'hABCD_1234);

      // Negative operand, nibble-sized steps.
      step("neg_s4",  1'b0, 32'hABCD_1234, 6'd4,  32'hFABC_D123);
      step("neg_s8",  1'b0, 32'hABCD_1234, 6'd8,  32'hFFAB_CD12);
      step("neg_s12", 1'b0, 32'hABCD_1234, 6'd12, 32'hFFFA_BCD1);
      step("neg_s16", 1'b0, 32'hABCD_1234, 6'd16, 32'hFFFF_ABCD);
      step("neg_s20", 1'b0, 32'hABCD_1234, 6'd20, 32'hFFFF_FABC);
      step("neg_s24", 1'b0, 32'hABCD_1234, 6'd24, 32'hFFFF_FFAB);
      step("neg_s28", 1'b0, 32'hABCD_1234, 6'd28, 32'hFFFF_FFFA);
      step("neg_s32", 1'b0, 32'hABCD_1234, 6'd32, 32'hFFFF_FFFF);

      // Positive operand; large amounts must not alias to small ones.
      step("pos_s4",  1'b0, 32'h7BCD_1234, 6'd4,  32'h07BC_D123);
      step("pos_s63", 1'b0, 32'h7BCD_1234, 6'd63, 32'h0000_0000);
      step("pos_s33", 1'b0, 32'h7BCD_1234, 6'd33, 32'h0000_0000);
      step("neg_s33", 1'b0, 32'hABCD_1234, 6'd33, 32'hFFFF_FFFF);
      step("pos_s31", 1'b0, 32'h7BCD_1234, 6'd31, 32'h0000_0000);
      step("pos_s1",  1'b0, 32'h7BCD_1234, 6'd1,  32'h3DE6_891A);

      // Most-negative value edges.
      step("min_s1",  1'b0, 32'h8000_0000, 6'd1,  32'hC000_0000);
      step("min_s31", 1'b0, 32'h8000_0000, 6'd31, 32'hFFFF_FFFF);
      step("min_s0",  1'b0, 32'h8000_0000, 6'd0,  32'h8000_0000);

      // Mid-stream reset then recovery.
      step("mid_rst",  1'b1, 32'h1234_5678, 6'd8, 32'h0000_0000);
      step("post_rst", 1'b0, 32'h1234_5678, 6'd8, 32'h0012_3456);

      // Random sweep against the language's arithmetic shift.
      for (int i = 0; i < 64; i++) begin
         rd   = $urandom;
         rs   = 6'($urandom_range(0, 63));
         rexp = 32'($signed(rd) >>> rs);
         step("rand", 1'b0, rd, rs, rexp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_filter_barrel_shifter
`default_nettype wire
